// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard and stall controller for the 5-stage MIPS core.
//   - Load-use hazard: holds PC and IF/ID for one cycle and drives the ID
//     control-mux select low so a bubble (all-zero control) enters ID/EX.
//   - Data-memory busy: freezes every pipeline register until the memory
//     completes; too many consecutive busy cycles lock the block in ERROR.
//   - Taken branch / jump: flushes IF/ID to a NOP on the next edge.
//   - Counts stall cycles (saturating) and keeps a sticky timeout error.
//
// Parameters
//   MAX_WAIT  consecutive busy cycles that trigger the timeout (1..255)
//   CNT_W     width of the stall-cycle counter
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-low reset
//   start_i         one-cycle pulse releasing the pipeline from IDLE
//   IDEX_MemRd_i    instruction in EX is a load
//   IDEX_Rt_i       destination register of that load
//   IFID_Rs_i       rs of the instruction in ID
//   IFID_Rt_i       rt of the instruction in ID
//   Branch_taken_i  branch in ID resolved taken
//   Jump_i          jump decoded in ID
//   Mem_busy_i      data memory has not completed its access
//   Ctrl_select_o   1 passes decoded control, 0 inserts a bubble
//   PC_Wr_o         PC write enable
//   IFID_Wr_o       IF/ID write enable
//   IFID_Flush_o    clear IF/ID to NOP on the next edge
//   Pipe_Wr_o       write enable for ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o     stall cycles since reset, saturating
//   err_o           sticky memory-timeout error
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IDEX_MemRd_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             Mem_busy_i,
  output logic             Ctrl_select_o,
  output logic             PC_Wr_o,
  output logic             IFID_Wr_o,
  output logic             IFID_Flush_o,
  output logic             Pipe_Wr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Wait-counter value seen on the last tolerated busy cycle. In RUN the
  // counter is 0, so MAX_WAIT=1 sends the very first busy cycle to ERROR
  // through the same comparison used in MEM_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err;

  logic w_hz;
  logic w_ctrl_sel;
  logic w_pc_wr;
  logic w_ifid_wr;
  logic w_ifid_flush;
  logic w_pipe_wr;
  logic w_counting;

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. Register 0 is hardwired to zero and never creates a dependency.
  assign w_hz = IDEX_MemRd_i && (IDEX_Rt_i != 5'd0) &&
                ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  // --------------------------------------------------------------------------
  // Next-state and Mealy outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_ctrl_sel   = 1'b0;
    w_pc_wr      = 1'b0;
    w_ifid_wr    = 1'b0;
    w_ifid_flush = 1'b0;
    w_pipe_wr    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (Mem_busy_i) begin
          // Full freeze. Control passes through unchanged so the frozen
          // ID/EX contents are not disturbed; memory stall outranks both
          // the load-use bubble and any flush.
          w_ctrl_sel = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = r_wait_cnt + 8'd1;
          end
        end else begin
          // Memory is ready: normal flow resumes in this same cycle.
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
          w_pipe_wr   = 1'b1;
          if (w_hz) begin
            // Bubble. A concurrent branch/jump is not flushed: its operands
            // are stale and it re-resolves next cycle.
            w_ctrl_sel = 1'b0;
          end else begin
            w_ctrl_sel   = 1'b1;
            w_pc_wr      = 1'b1;
            w_ifid_wr    = 1'b1;
            w_ifid_flush = Branch_taken_i || Jump_i;
          end
        end
      end

      ST_ERROR: begin
        // Everything held at zero; only reset leaves this state.
        w_state_nxt = ST_ERROR;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  // A stall cycle is any active-pipeline cycle in which the PC is held.
  assign w_counting = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) &&
                      !w_pc_wr;

  // --------------------------------------------------------------------------
  // State, wait counter, stall counter and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_counting && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_state_nxt == ST_ERROR) begin
        r_err <= 1'b1;
      end
    end
  end

  assign Ctrl_select_o = w_ctrl_sel;
  assign PC_Wr_o       = w_pc_wr;
  assign IFID_Wr_o     = w_ifid_wr;
  assign IFID_Flush_o  = w_ifid_flush;
  assign Pipe_Wr_o     = w_pipe_wr;
  assign stall_cnt_o   = r_stall_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Scoreboard bench for hazard_stall_ctrl. The stimulus process drives one
// cycle at a time, asks a behavioural model what the block must show during
// that cycle and queues the answer; a monitor on the falling edge pops and
// compares. The DUT is built with a short timeout and a 4-bit stall counter
// so that both the timeout and the counter saturation are reachable.
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic             IDEX_MemRd_i;
  logic [4:0]       IDEX_Rt_i;
  logic [4:0]       IFID_Rs_i;
  logic [4:0]       IFID_Rt_i;
  logic             Branch_taken_i;
  logic             Jump_i;
  logic             Mem_busy_i;
  logic             Ctrl_select_o;
  logic             PC_Wr_o;
  logic             IFID_Wr_o;
  logic             IFID_Flush_o;
  logic             Pipe_Wr_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             err_o;

  hazard_stall_ctrl #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IDEX_MemRd_i   (IDEX_MemRd_i),
    .IDEX_Rt_i      (IDEX_Rt_i),
    .IFID_Rs_i      (IFID_Rs_i),
    .IFID_Rt_i      (IFID_Rt_i),
    .Branch_taken_i (Branch_taken_i),
    .Jump_i         (Jump_i),
    .Mem_busy_i     (Mem_busy_i),
    .Ctrl_select_o  (Ctrl_select_o),
    .PC_Wr_o        (PC_Wr_o),
    .IFID_Wr_o      (IFID_Wr_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .Pipe_Wr_o      (Pipe_Wr_o),
    .stall_cnt_o    (stall_cnt_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       sel;
    logic       pc;
    logic       ifid;
    logic       flush;
    logic       pipe;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  // Behavioural model: the controller is either idle, running (possibly
  // stuck behind a busy memory for m_streak cycles) or dead.
  int m_phase;   // 0 idle, 1 running, 2 dead
  int m_streak;  // consecutive busy cycles seen while running
  int m_cnt;     // stall cycles so far

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the expected response for that cycle.
  task automatic drive(input bit rst, input bit st, input bit mrd,
                       input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input bit br, input bit jp,
                       input bit busy);
    exp_t e;
    bit   hz;
    @(posedge clk_i);
    #1;
    rst_i          = rst;
    start_i        = st;
    IDEX_MemRd_i   = mrd;
    IDEX_Rt_i      = irt;
    IFID_Rs_i      = rs;
    IFID_Rt_i      = rt;
    Branch_taken_i = br;
    Jump_i         = jp;
    Mem_busy_i     = busy;

    e = '0;
    if (!rst) begin
      m_phase  = 0;
      m_streak = 0;
      m_cnt    = 0;
    end else begin
      hz    = mrd && (irt != 0) && ((irt == rs) || (irt == rt));
      e.cnt = 8'(m_cnt);
      e.err = (m_phase == 2);
      if (m_phase == 0) begin
        if (st) m_phase = 1;
      end else if (m_phase == 1) begin
        if (busy) begin
          e.sel = 1'b1;
          m_streak++;
          if (m_streak >= MAX_WAIT) m_phase = 2;
        end else begin
          m_streak = 0;
          e.pipe   = 1'b1;
          if (!hz) begin
            e.sel   = 1'b1;
            e.pc    = 1'b1;
            e.ifid  = 1'b1;
            e.flush = br || jp;
          end
        end
        if (!e.pc && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic nop(input bit busy);
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, busy);
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("Ctrl_select_o", 32'(Ctrl_select_o), 32'(e.sel));
        check("PC_Wr_o",       32'(PC_Wr_o),       32'(e.pc));
        check("IFID_Wr_o",     32'(IFID_Wr_o),     32'(e.ifid));
        check("IFID_Flush_o",  32'(IFID_Flush_o),  32'(e.flush));
        check("Pipe_Wr_o",     32'(Pipe_Wr_o),     32'(e.pipe));
        check("err_o",         32'(err_o),         32'(e.err));
        check("stall_cnt_o",   32'(stall_cnt_o),   32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst;
    bit busy;
    checks    = 0;
    errors    = 0;
    stim_done = 0;
    m_phase   = 0;
    m_streak  = 0;
    m_cnt     = 0;
    rst_i          = 1'b0;
    start_i        = 1'b0;
    IDEX_MemRd_i   = 1'b0;
    IDEX_Rt_i      = 5'd0;
    IFID_Rs_i      = 5'd0;
    IFID_Rt_i      = 5'd0;
    Branch_taken_i = 1'b0;
    Jump_i         = 1'b0;
    Mem_busy_i     = 1'b0;

    // Reset and IDLE: all zero, start_i absent keeps IDLE.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 8, 8, 8, 1, 1, 1);
    drive(1, 0, 1, 8, 8, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);           // start pulse
    repeat (3) nop(0);                           // clean run
    drive(1, 0, 1, 8, 8, 0, 0, 0, 0);           // load-use on rs
    nop(0);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);           // $zero never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);           // taken branch flushes
    nop(0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);           // jump flushes
    drive(1, 0, 1, 9, 3, 9, 1, 0, 0);           // hz on rt beats branch
    drive(1, 1, 1, 9, 3, 9, 1, 0, 1);           // busy beats hz/flush
    repeat (2) nop(1);                           // three busy cycles total
    nop(0);                                      // resumes immediately
    repeat (18) drive(1, 0, 1, 7, 7, 1, 0, 0, 0); // drive counter to saturation
    repeat (2) nop(0);
    repeat (6) nop(1);                           // timeout into ERROR
    drive(1, 1, 0, 0, 0, 0, 1, 1, 0);           // start ignored in ERROR
    nop(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);           // reset out of ERROR
    nop(0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nop(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);           // reset mid memory stall
    nop(0);

    // Randomised episodes with small register numbers so hazards are common.
    burst = 0;
    for (int ep = 0; ep < 40; ep++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 55; c++) begin
        if (burst > 0) begin
          busy = 1'b1;
          burst--;
        end else if ($urandom_range(0, 7) == 0) begin
          busy  = 1'b1;
          burst = $urandom_range(0, 5);
        end else begin
          busy = 1'b0;
        end
        drive(($urandom_range(0, 199) != 0),
              (c == 1) || ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0),
              busy);
      end
    end

    stim_done = 1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk_i);
    @(posedge clk_i);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Detects load-use hazards and inserts a one-cycle bubble by driving the select of the ID-stage control-signal mux. A deasserted select zeroes every control signal into ID/EX.
- Freezes the whole pipeline while the data memory reports busy, and flushes IF/ID on taken branch or jump.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

Parameters:
- MAX_WAIT, 16: maximum consecutive Mem_busy_i cycles before the timeout error; range 1..255.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that releases the pipeline from IDLE.
- IDEX_MemRd_i  in  1  instruction in EX is a load.
- IDEX_Rt_i  in  5  destination register of the load in EX.
- IFID_Rs_i  in  5  rs of the instruction in ID.
- IFID_Rt_i  in  5  rt of the instruction in ID.
- Branch_taken_i  in  1  branch in ID resolved taken.
- Jump_i  in  1  jump decoded in ID.
- Mem_busy_i  in  1  data memory has not completed its access.
- Ctrl_select_o  out  1  control-mux select: 1 passes decoded control, 0 inserts a bubble.
- PC_Wr_o  out  1  PC write enable.
- IFID_Wr_o  out  1  IF/ID write enable.
- IFID_Flush_o  out  1  clear IF/ID to NOP on the next edge.
- Pipe_Wr_o  out  1  write enable for ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  stall cycles since reset, saturating.
- err_o  out  1  sticky memory-timeout error.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; wait counter, stall_cnt_o and err_o clear to 0.
  - All outputs read 0 in IDLE: Ctrl_select_o=0, PC_Wr_o=0, IFID_Wr_o=0, IFID_Flush_o=0, Pipe_Wr_o=0.
  - Reset asserted mid-stall or in ERROR returns to IDLE immediately.
- States are IDLE, RUN, MEM_WAIT and ERROR. State is registered; outputs are combinational from state and inputs (Mealy), with zero latency.
- IDLE:
  - Enter RUN on the edge where start_i=1.
  - start_i is ignored in every other state.
- Load-use hazard, hz:
  - hz = IDEX_MemRd_i & (IDEX_Rt_i != 0) & ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i)).
- RUN with Mem_busy_i=0:
  - Pipe_Wr_o=1.
  - If hz: Ctrl_select_o=0, PC_Wr_o=0, IFID_Wr_o=0, IFID_Flush_o=0. Exactly one bubble results, because the load leaves EX on the next edge.
  - Else: Ctrl_select_o=1, PC_Wr_o=1, IFID_Wr_o=1, IFID_Flush_o = Branch_taken_i | Jump_i.
  - hz together with Branch_taken_i or Jump_i: the stall wins and the flush is suppressed, because the ID operands are stale. The branch re-resolves next cycle.
- RUN with Mem_busy_i=1:
  - Freeze: Pipe_Wr_o=0, PC_Wr_o=0, IFID_Wr_o=0, IFID_Flush_o=0, Ctrl_select_o=1.
  - Go to MEM_WAIT with wait counter=1.
  - Memory stall has priority over hz and over flush.
- MEM_WAIT:
  - Outputs are frozen as above while Mem_busy_i=1.
  - When Mem_busy_i=0, outputs follow the RUN rules in that same cycle, and the state returns to RUN with wait counter=0.
  - While busy, the wait counter increments. On the edge where Mem_busy_i=1 and wait counter == MAX_WAIT-1, go to ERROR instead.
  - With MAX_WAIT=1, any busy cycle seen in RUN goes directly to ERROR.
- ERROR:
  - All write enables 0, Ctrl_select_o=0, err_o=1.
  - Leave only by reset.
- Stall counter:
  - stall_cnt_o increments on each edge where the state is RUN or MEM_WAIT and PC_Wr_o=0. ERROR cycles are not counted.
  - Saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset, then start_i pulse, no hazards: PC_Wr_o=IFID_Wr_o=Pipe_Wr_o=Ctrl_select_o=1 from the first RUN cycle; stall_cnt_o stays 0.
- IDEX_MemRd_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 for one cycle: that cycle shows Ctrl_select_o=0, PC_Wr_o=0, IFID_Wr_o=0, Pipe_Wr_o=1; stall_cnt_o=1. Repeat with IDEX_Rt_i=0: no stall.
- Branch_taken_i=1 without hz: IFID_Flush_o=1 for exactly that cycle. Branch_taken_i=1 with hz (Rt match on IFID_Rt_i): IFID_Flush_o=0 and bubble inserted.
- Mem_busy_i high for 3 cycles, MAX_WAIT=16: Pipe_Wr_o=PC_Wr_o=0 for exactly 3 cycles, resumes the same cycle busy drops, stall_cnt_o +=3, err_o=0.
- Mem_busy_i held high with MAX_WAIT=4: ERROR entered after 4 busy cycles; err_o=1 and all enables 0 until rst_i=0, after which state is IDLE and all outputs are 0.
- Force stall_cnt_o to saturation with CNT_W=4 (16+ stalls): counter holds at 15.
